orbis32_qed_scheduler: RTL and testbench

Sequences the instruction stream into the OpenRISC core under SQED checking. Original instructions use registers r0–r15 and arrive from the symbolic instruction source; they are issued directly and buffered. On request, the block replays each buffered original as its duplicate, remapped to r16–r31. Once every original has been duplicated it flags a consistency-check point. It sits between the symbolic instruction source/constraint layer and the core fetch stage.

---
 rtl/orbis32_qed_scheduler_if.sv | 34 +++
 rtl/orbis32_qed_scheduler.sv | 165 ++++++++++++++++
 tb/tb_orbis32_qed_scheduler.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/orbis32_qed_scheduler_if.sv
// orbis32_qed_scheduler_if: instruction-side bundle between the symbolic
// instruction source / fetch stage and the SQED scheduler.
//
// Handshake: ena is the fetch stage's accept strobe. The scheduler advances
// state only on rising clk edges where ena=1. qed_instruction is valid for
// the core when qed_vld=1. A cycle with qed_vld=0 carries filler NOP, or a
// held value while ena=0. There is no back-pressure towards the source:
// an ifu_instruction presented on an ena=1 edge is either taken or dropped
// as filler on that same edge.
interface orbis32_qed_scheduler_if #(
    parameter int CNT_W = 5
);
    logic             ena;
    logic             exec_dup;
    logic [31:0]      ifu_instruction;
    logic [31:0]      qed_instruction;
    logic             qed_vld;
    logic             qed_ready;
    logic [CNT_W-1:0] orig_count;
    logic [CNT_W-1:0] dup_count;
    logic [1:0]       dbg_state;

    // Source/fetch side
    modport master (
        output ena, exec_dup, ifu_instruction,
        input  qed_instruction, qed_vld, qed_ready, orig_count, dup_count, dbg_state
    );

    // Scheduler side
    modport slave (
        input  ena, exec_dup, ifu_instruction,
        output qed_instruction, qed_vld, qed_ready, orig_count, dup_count, dbg_state
    );
endinterface

// File: rtl/orbis32_qed_scheduler.sv
// orbis32_qed_scheduler: issues original instructions (r0-r15), buffers
// them, then replays each one as its duplicate remapped to r16-r31, and
// finally raises qed_ready as the consistency-check point.
//
// Optional feature macro: QED_MEM_SPLIT_EN
//   defined     - loads and stores are issued, buffered and duplicated
//                 into the upper memory half.
//   not defined - loads and stores in the original stream become filler.
//
// dbg_state encoding: 0 = ORIG, 1 = DUP, 2 = DONE.
module orbis32_qed_scheduler #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    orbis32_qed_scheduler_if.slave bus
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h1500_0000;

    typedef enum logic [1:0] {
        S_ORIG = 2'd0,
        S_DUP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      instr_q, instr_d;
    logic             vld_q, vld_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] orig_q, orig_d;
    logic [CNT_W-1:0] dupc_q, dupc_d;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic             push;
    logic             accept;

    logic [31:0] mem_q [DEPTH];

    // Duplicate form: set bit 4 of every register field the opcode uses.
    function automatic logic [31:0] dup_xform(input logic [31:0] ins);
        logic [31:0] r;
        r = ins;
        case (ins[31:26])
            6'b111000, 6'b110010: r = ins | 32'h0210_8000;
            6'b100111, 6'b101001, 6'b101010,
            6'b101011, 6'b101100, 6'b101110: r = ins | 32'h0210_0000;
`ifdef QED_MEM_SPLIT_EN
            6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110: r = ins | 32'h0200_4000;
            6'b110101, 6'b110110, 6'b110111: r = ins | 32'h0100_8000;
`endif
            default: r = ins;
        endcase
        return r;
    endfunction

    // Decide whether the current source instruction is a real original.
`ifdef QED_MEM_SPLIT_EN
    always_comb begin
        accept = (bus.ifu_instruction != NOP);
    end
`else
    logic is_mem;
    always_comb begin
        is_mem = 1'b0;
        case (bus.ifu_instruction[31:26])
            6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110,
            6'b110101, 6'b110110, 6'b110111: is_mem = 1'b1;
            default:                         is_mem = 1'b0;
        endcase
        accept = (bus.ifu_instruction != NOP) && !is_mem;
    end
`endif

    // Next-state and output decode; everything holds while ena is low.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        vld_d   = 1'b0;
        ready_d = ready_q;
        orig_d  = orig_q;
        dupc_d  = dupc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        push    = 1'b0;
        if (bus.ena) begin
            case (state_q)
                S_ORIG: begin
                    instr_d = NOP;
                    if (accept) begin
                        instr_d = bus.ifu_instruction;
                        vld_d   = 1'b1;
                        push    = 1'b1;
                        wr_d    = wr_q + 1'b1;
                        orig_d  = orig_q + 1'b1;
                    end
                    // Buffer fills on this push, or an explicit request once
                    // at least one original already went out.
                    if ((bus.exec_dup && (orig_q != '0)) ||
                        (accept && (orig_q == CNT_W'(DEPTH - 1)))) begin
                        state_d = S_DUP;
                    end
                end
                S_DUP: begin
                    instr_d = dup_xform(mem_q[rd_q]);
                    vld_d   = 1'b1;
                    rd_d    = rd_q + 1'b1;
                    dupc_d  = dupc_q + 1'b1;
                    if ((dupc_q + 1'b1) == orig_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    instr_d = NOP;
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = S_ORIG;
                end
            endcase
        end
    end

    // State, output and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_ORIG;
            instr_q <= NOP;
            vld_q   <= 1'b0;
            ready_q <= 1'b0;
            orig_q  <= '0;
            dupc_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            ready_q <= ready_d;
            orig_q  <= orig_d;
            dupc_q  <= dupc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Original-instruction buffer; contents survive reset, pointers do not.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_q] <= bus.ifu_instruction;
        end
    end

    assign bus.qed_instruction = instr_q;
    assign bus.qed_vld         = vld_q;
    assign bus.qed_ready       = ready_q;
    assign bus.orig_count      = orig_q;
    assign bus.dup_count       = dupc_q;
    assign bus.dbg_state       = state_q;

endmodule

// File: tb/tb_orbis32_qed_scheduler.sv
// Testbench for orbis32_qed_scheduler: table of per-edge vectors plus a
// hand-written full-buffer run using an expected queue.
module tb_orbis32_qed_scheduler;

    localparam logic [31:0] N      = 32'h1500_0000;
    localparam logic [31:0] ADD    = 32'hE022_1800;
    localparam logic [31:0] ADD_D  = 32'hE232_9800;
    localparam logic [31:0] ADDI   = 32'h9C22_0005;
    localparam logic [31:0] ADDI_D = 32'h9E32_0005;
    localparam logic [31:0] XORI   = 32'hE064_2805;
    localparam logic [31:0] XOR_D  = 32'hE274_A805;
    localparam logic [31:0] SLLI   = 32'hB8C7_0002;
    localparam logic [31:0] SLLI_D = 32'hBAD7_0002;
    localparam logic [31:0] FADD   = 32'hC822_1800;
    localparam logic [31:0] FADD_D = 32'hCA32_9800;
    localparam logic [31:0] MOVHI  = 32'h1880_1234;
    localparam logic [31:0] LWZ    = 32'h8480_0010;
    localparam logic [31:0] LWZ_D  = 32'h8680_4010;
    localparam logic [31:0] SW     = 32'hD401_1008;
    localparam logic [31:0] SW_D   = 32'hD501_9008;
    localparam logic [1:0]  ORIG = 2'd0, DUP = 2'd1, DONE = 2'd2;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    orbis32_qed_scheduler_if #(.CNT_W(5)) bus ();

    orbis32_qed_scheduler #(.DEPTH(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        ena;
        logic        xd;
        logic [31:0] ifu;
        logic [31:0] e_ins;
        logic        e_vld;
        logic        e_rdy;
        logic [4:0]  e_orig;
        logic [4:0]  e_dup;
        logic [1:0]  e_st;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    function automatic vec_t mk(logic r, logic e, logic x, logic [31:0] i,
                                logic [31:0] ei, logic ev, logic er,
                                logic [4:0] eo, logic [4:0] ed, logic [1:0] es);
        vec_t v;
        v.rst = r; v.ena = e; v.xd = x; v.ifu = i;
        v.e_ins = ei; v.e_vld = ev; v.e_rdy = er;
        v.e_orig = eo; v.e_dup = ed; v.e_st = es;
        return v;
    endfunction

    // driver: present inputs, take one edge, settle away from the edge
    task automatic step(input logic r, input logic e, input logic x, input logic [31:0] i);
        rst                 = r;
        bus.ena             = e;
        bus.exec_dup        = x;
        bus.ifu_instruction = i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] ei, input logic ev,
                       input logic er, input logic [4:0] eo, input logic [4:0] ed,
                       input logic [1:0] es);
        n_cmp += 6;
        if (bus.qed_instruction !== ei) begin
            n_fail++;
            $display("FAIL %s qed_instruction got %08h want %08h", name, bus.qed_instruction, ei);
        end
        if (bus.qed_vld !== ev) begin
            n_fail++;
            $display("FAIL %s qed_vld got %0b want %0b", name, bus.qed_vld, ev);
        end
        if (bus.qed_ready !== er) begin
            n_fail++;
            $display("FAIL %s qed_ready got %0b want %0b", name, bus.qed_ready, er);
        end
        if (bus.orig_count !== eo) begin
            n_fail++;
            $display("FAIL %s orig_count got %0d want %0d", name, bus.orig_count, eo);
        end
        if (bus.dup_count !== ed) begin
            n_fail++;
            $display("FAIL %s dup_count got %0d want %0d", name, bus.dup_count, ed);
        end
        if (bus.dbg_state !== es) begin
            n_fail++;
            $display("FAIL %s state got %0d want %0d", name, bus.dbg_state, es);
        end
    endtask

    initial begin
        logic [4:0]  o;
        logic [31:0] ins;
        logic [31:0] e;
`ifdef QED_MEM_SPLIT_EN
        o = 5'd7;
`else
        o = 5'd5;
`endif
        // reset, then hold with ena low and changing inputs
        vecs.push_back(mk(1, 1, 1, ADD,  N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(1, 0, 0, ADD,  N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 0, 1, ADD,  N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 0, 0, LWZ,  N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 0, 1, XORI, N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 0, 0, N,    N, 0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 0, 1, SLLI, N, 0, 0, 0, 0, ORIG));
        // basic pair, then exec_dup in DONE
        vecs.push_back(mk(0, 1, 0, ADD, ADD,   1, 0, 1, 0, ORIG));
        vecs.push_back(mk(0, 1, 1, N,   N,     0, 0, 1, 0, DUP));
        vecs.push_back(mk(0, 1, 0, N,   ADD_D, 1, 0, 1, 1, DONE));
        vecs.push_back(mk(0, 1, 1, ADD, N,     0, 1, 1, 1, DONE));
        vecs.push_back(mk(0, 1, 1, ADD, N,     0, 1, 1, 1, DONE));
        vecs.push_back(mk(0, 0, 1, ADD, N,     0, 1, 1, 1, DONE));
        // early exec_dup, ordering with stalls, memory ops
        vecs.push_back(mk(1, 1, 0, N,     N,     0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 1, 1, N,     N,     0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 1, 1, ADDI,  ADDI,  1, 0, 1, 0, ORIG));
        vecs.push_back(mk(0, 0, 0, XORI,  ADDI,  0, 0, 1, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, XORI,  XORI,  1, 0, 2, 0, ORIG));
        vecs.push_back(mk(0, 0, 0, SLLI,  XORI,  0, 0, 2, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, SLLI,  SLLI,  1, 0, 3, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, FADD,  FADD,  1, 0, 4, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, MOVHI, MOVHI, 1, 0, 5, 0, ORIG));
`ifdef QED_MEM_SPLIT_EN
        vecs.push_back(mk(0, 1, 0, LWZ,   LWZ,   1, 0, 6, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, SW,    SW,    1, 0, 7, 0, ORIG));
`else
        vecs.push_back(mk(0, 1, 0, LWZ,   N,     0, 0, 5, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, SW,    N,     0, 0, 5, 0, ORIG));
`endif
        vecs.push_back(mk(0, 1, 1, N, N,      0, 0, o, 0, DUP));
        vecs.push_back(mk(0, 1, 0, N, ADDI_D, 1, 0, o, 1, DUP));
        vecs.push_back(mk(0, 0, 0, N, ADDI_D, 0, 0, o, 1, DUP));
        vecs.push_back(mk(0, 1, 0, N, XOR_D,  1, 0, o, 2, DUP));
        vecs.push_back(mk(0, 0, 1, N, XOR_D,  0, 0, o, 2, DUP));
        vecs.push_back(mk(0, 1, 0, N, SLLI_D, 1, 0, o, 3, DUP));
        vecs.push_back(mk(0, 1, 0, N, FADD_D, 1, 0, o, 4, DUP));
`ifdef QED_MEM_SPLIT_EN
        vecs.push_back(mk(0, 1, 0, N, MOVHI, 1, 0, 7, 5, DUP));
        vecs.push_back(mk(0, 1, 0, N, LWZ_D, 1, 0, 7, 6, DUP));
        vecs.push_back(mk(0, 1, 0, N, SW_D,  1, 0, 7, 7, DONE));
        vecs.push_back(mk(0, 1, 0, N, N,     0, 1, 7, 7, DONE));
`else
        vecs.push_back(mk(0, 1, 0, N, MOVHI, 1, 0, 5, 5, DONE));
        vecs.push_back(mk(0, 1, 0, N, N,     0, 1, 5, 5, DONE));
`endif
        // reset in the middle of DUP, then a fresh run
        vecs.push_back(mk(1, 1, 0, N,    N,      0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, XORI, XORI,   1, 0, 1, 0, ORIG));
        vecs.push_back(mk(0, 1, 1, ADDI, ADDI,   1, 0, 2, 0, DUP));
        vecs.push_back(mk(0, 1, 0, N,    XOR_D,  1, 0, 2, 1, DUP));
        vecs.push_back(mk(1, 1, 0, N,    N,      0, 0, 0, 0, ORIG));
        vecs.push_back(mk(0, 1, 0, SLLI, SLLI,   1, 0, 1, 0, ORIG));
        vecs.push_back(mk(0, 1, 1, N,    N,      0, 0, 1, 0, DUP));
        vecs.push_back(mk(0, 1, 0, N,    SLLI_D, 1, 0, 1, 1, DONE));
        vecs.push_back(mk(0, 1, 0, N,    N,      0, 1, 1, 1, DONE));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].ena, vecs[i].xd, vecs[i].ifu);
            chk($sformatf("vec%0d", i), vecs[i].e_ins, vecs[i].e_vld, vecs[i].e_rdy,
                vecs[i].e_orig, vecs[i].e_dup, vecs[i].e_st);
        end

        // full buffer: 16 originals force DUP without exec_dup
        step(1, 0, 0, N);
        chk("full_rst", N, 0, 0, 0, 0, ORIG);
        for (int i = 0; i < 16; i++) begin
            ins = {6'b100111, 5'(i), 5'((i + 1) % 16), 16'(i * 3 + 1)};
            exp_q.push_back(ins | 32'h0210_0000);
            step(0, 1, 0, ins);
            chk($sformatf("full_push%0d", i), ins, 1, 0, 5'(i + 1), 0,
                (i == 15) ? DUP : ORIG);
        end
        for (int i = 0; i < 16; i++) begin
            e = exp_q.pop_front();
            step(0, 1, 0, N);
            chk($sformatf("full_pop%0d", i), e, 1, 0, 5'd16, 5'(i + 1),
                (i == 15) ? DONE : DUP);
        end
        step(0, 1, 1, ADD);
        chk("full_ready", N, 0, 1, 5'd16, 5'd16, DONE);

        // second run after reset exercises the wrapped-to-zero pointers
        step(1, 0, 0, N);
        step(0, 1, 0, FADD);
        chk("wrap_push", FADD, 1, 0, 1, 0, ORIG);
        step(0, 1, 1, N);
        step(0, 1, 0, N);
        chk("wrap_pop", FADD_D, 1, 0, 1, 1, DONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
